alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands and result.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 r0_valid / r1_valid  input  1 each  requester 0/1 presents an operation.
REQ-005 r0_ready / r1_ready  output  1 each  requester 0/1 operation accepted this cycle (valid AND ready).
REQ-006 rN_data1, rN_data2  input  XLEN each  operands, per requester.
REQ-007 rN_optype  input  7  major opcode, per requester (I-type or R-type ALU opcode).
REQ-008 rN_aluop  input  3  funct3 operation select, per requester.
REQ-009 rN_funct7  input  7  funct7 qualifier, per requester.
REQ-010 rsp_valid  output  1  response held until accepted.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_id  output  1  index of the requester that owns the response.
REQ-013 rsp_result  output  XLEN  ALU result.
REQ-014 rsp_zero, rsp_carry  output  1 each  ALU zero and carry flags.
REQ-015 rsp_err  output  1  optype was neither I-type nor R-type ALU opcode.

Function
REQ-016 FSM states IDLE, EXEC, RESP; one operation in flight at most.
REQ-017 IDLE: if any rN_valid, grant exactly one, assert its rN_ready, capture operands, optype, aluop, funct7 and id into operand registers, go EXEC.
REQ-018 rN_ready SHALL be combinational from state and valids; never asserted for both requesters in one cycle; never asserted in EXEC.
REQ-019 EXEC: the instantiated ALU evaluates the captured operands; result, zero, carry, err and id are registered into the response registers; go RESP.
REQ-020 RESP: rsp_valid=1; all rsp_* outputs stable until rsp_valid AND rsp_ready.
REQ-021 RESP with rsp_ready=1: if any rN_valid, grant and capture in the same cycle and go EXEC; else go IDLE.
REQ-022 RESP with rsp_ready=0: no grant, remain RESP.
REQ-023 Latency: request accepted at cycle N gives rsp_valid at cycle N+2; peak throughput one operation per 2 cycles.
REQ-024 rsp_err=1 and rsp_result=0, rsp_zero=1, rsp_carry=0 when captured optype is not OP_ITYPE or OP_RTYPE.
REQ-025 Shift amount is data2[4:0]; SRA/SRAI selected by funct7 exactly as the ALU defines.
REQ-026 A requester dropping valid before being granted is legal; no state change.

Reset
REQ-027 While rst_n=0: state=IDLE, rsp_valid=0, r0_ready=r1_ready=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_carry=0, rsp_err=0, last-grant pointer=1.
REQ-028 Reset mid-operation discards the in-flight operation; no response is produced for it.
REQ-029 First grant after reset with both valids goes to requester 0.

Configuration
REQ-030 Macro ALU_ARB_RR_EN defined: round-robin; on simultaneous valids grant the requester not equal to last-grant pointer; pointer updates on every grant.
REQ-031 Macro ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins; pointer held at reset value.

Structure
REQ-032 Shared package holds XLEN default, OP_ITYPE/OP_RTYPE opcodes, funct3 ALU op codes, FUNCT7 default/SUB-SRA codes, ZERO constant, FSM state encoding.
REQ-033 One sub-module: the existing ALU, instantiated once, fed only from the operand registers.

Verification
REQ-034 r0: R-type ADD 5+7, rsp_ready=1 -> rsp_valid two cycles after accept, result=12, zero=0, rsp_id=0.
REQ-035 Both valid every cycle, rsp_ready=1, RR enabled -> grants 0,1,0,1; without macro -> grants 0,0,0,0.
REQ-036 r1: I-type SRAI data1=0x80000000 shamt=4, funct7 SRA -> result=0xF8000000, rsp_id=1.
REQ-037 rsp_ready held 0 for 5 cycles -> rsp_* stable, r0_ready=r1_ready=0; release -> next grant same cycle.
REQ-038 optype=0x63 -> rsp_err=1, result=0, zero=1, carry=0.
REQ-039 rst_n low in EXEC -> no rsp_valid after release; outputs at reset values; next request served normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared constants and types for the ALU arbiter
//
// Holds the default datapath width, the two ALU major opcodes, the funct3
// operation codes, the funct7 qualifiers, a zero constant and the arbiter
// FSM state encoding. Imported by alu_arbiter and alu_arbiter_alu.
package alu_arbiter_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Major opcodes the ALU accepts; anything else is flagged as an error.
  localparam logic [6:0] OP_ITYPE = 7'h13;
  localparam logic [6:0] OP_RTYPE = 7'h33;

  // funct3 operation select
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // funct7 qualifiers
  localparam logic [6:0] FUNCT7_DEFAULT = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB_SRA = 7'b0100000;

  localparam logic [XLEN_DEFAULT-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational integer ALU shared by both requesters
//
// Ports:
//   optype_i  major opcode (OP_ITYPE or OP_RTYPE, otherwise err_o)
//   aluop_i   funct3 operation select
//   funct7_i  funct7 qualifier (SUB for R-type ADD, SRA for both shift forms)
//   data1_i   first operand
//   data2_i   second operand / immediate; shift amount is data2_i[4:0]
//   result_o  operation result (zero on error)
//   zero_o    result is all zeros
//   carry_o   carry out of ADD, borrow out of SUB, zero otherwise
//   err_o     optype_i was not an ALU opcode
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [6:0]      optype_i,
  input  logic [2:0]      aluop_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            carry_o,
  output logic            err_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;
  logic [4:0]    shamt;
  logic          is_r;
  logic          is_i;
  logic          alt;

  assign sum   = {1'b0, data1_i} + {1'b0, data2_i};
  assign diff  = {1'b0, data1_i} - {1'b0, data2_i};
  assign shamt = data2_i[4:0];
  assign is_r  = (optype_i == OP_RTYPE);
  assign is_i  = (optype_i == OP_ITYPE);
  assign alt   = (funct7_i == FUNCT7_SUB_SRA);

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    err_o    = 1'b0;
    if (!(is_r || is_i)) begin
      err_o = 1'b1;
    end else begin
      case (aluop_i)
        // ADDI carries an immediate in data2, so funct7 only selects SUB for R-type.
        ALU_ADD: begin
          if (is_r && alt) {carry_o, result_o} = diff;
          else             {carry_o, result_o} = sum;
        end
        ALU_SLL:  result_o = data1_i << shamt;
        ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
        ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (data1_i < data2_i)};
        ALU_XOR:  result_o = data1_i ^ data2_i;
        ALU_SRL: begin
          if (alt) result_o = XLEN'($signed(data1_i) >>> shamt);
          else     result_o = data1_i >> shamt;
        end
        ALU_OR:   result_o = data1_i | data2_i;
        default:  result_o = data1_i & data2_i;
      endcase
    end
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a single shared ALU
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rN_valid / rN_ready        requester N handshake (ready is combinational)
//   rN_data1, rN_data2         requester N operands
//   rN_optype, rN_aluop,
//   rN_funct7                  requester N opcode, funct3, funct7
//   rsp_valid / rsp_ready      response handshake, response held until taken
//   rsp_id                     requester that owns the response
//   rsp_result, rsp_zero,
//   rsp_carry, rsp_err         registered ALU outputs
//
// Configuration macro ALU_ARB_RR_EN: when defined, simultaneous requests
// alternate using a last-grant pointer; otherwise requester 0 always wins.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [XLEN-1:0] r0_data1,
  input  logic [XLEN-1:0] r0_data2,
  input  logic [6:0]      r0_optype,
  input  logic [2:0]      r0_aluop,
  input  logic [6:0]      r0_funct7,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [XLEN-1:0] r1_data1,
  input  logic [XLEN-1:0] r1_data2,
  input  logic [6:0]      r1_optype,
  input  logic [2:0]      r1_aluop,
  input  logic [6:0]      r1_funct7,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            rsp_carry,
  output logic            rsp_err
);

  arb_state_e state_q, state_d;

  logic can_grant;
  logic pick1;
  logic gnt0;
  logic gnt1;
  logic gnt_any;

  // Grants happen from IDLE or from a RESP whose response is being taken;
  // gating with rst_n keeps both readies low while reset is held.
  assign can_grant = rst_n &&
                     ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;
  // On a tie requester 1 wins only if requester 0 was granted last.
  assign pick1  = r1_valid && (!r0_valid || !last_q);
  assign last_d = gnt_any ? gnt1 : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  // Fixed priority: the last-grant pointer never moves from its reset value
  // and plays no part in the decision, so no register is kept for it.
  assign pick1 = r1_valid && !r0_valid;
`endif

  assign gnt1     = can_grant && pick1;
  assign gnt0     = can_grant && r0_valid && !pick1;
  assign gnt_any  = gnt0 || gnt1;
  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_any) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = gnt_any ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand registers: the only source feeding the ALU.
  logic [XLEN-1:0] op_data1_q, op_data2_q;
  logic [6:0]      op_optype_q, op_funct7_q;
  logic [2:0]      op_aluop_q;
  logic            op_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_data1_q  <= XLEN'(ZERO);
      op_data2_q  <= XLEN'(ZERO);
      op_optype_q <= 7'd0;
      op_aluop_q  <= 3'd0;
      op_funct7_q <= 7'd0;
      op_id_q     <= 1'b0;
    end else if (gnt_any) begin
      op_data1_q  <= gnt1 ? r1_data1  : r0_data1;
      op_data2_q  <= gnt1 ? r1_data2  : r0_data2;
      op_optype_q <= gnt1 ? r1_optype : r0_optype;
      op_aluop_q  <= gnt1 ? r1_aluop  : r0_aluop;
      op_funct7_q <= gnt1 ? r1_funct7 : r0_funct7;
      op_id_q     <= gnt1;
    end
  end

  logic [XLEN-1:0] alu_result;
  logic            alu_zero, alu_carry, alu_err;

  alu_arbiter_alu #(.XLEN(XLEN)) u_alu (
    .optype_i (op_optype_q),
    .aluop_i  (op_aluop_q),
    .funct7_i (op_funct7_q),
    .data1_i  (op_data1_q),
    .data2_i  (op_data2_q),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .carry_o  (alu_carry),
    .err_o    (alu_err)
  );

  // Response registers load only in EXEC, so they stay frozen through RESP.
  logic [XLEN-1:0] rsp_result_q;
  logic            rsp_zero_q, rsp_carry_q, rsp_err_q, rsp_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= XLEN'(ZERO);
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_result_q <= alu_result;
      rsp_zero_q   <= alu_zero;
      rsp_carry_q  <= alu_carry;
      rsp_err_q    <= alu_err;
      rsp_id_q     <= op_id_q;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam logic [6:0] OPI = 7'h13;
  localparam logic [6:0] OPR = 7'h33;
  localparam logic [6:0] F7S = 7'h20;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [31:0] r0_data1 = '0, r0_data2 = '0, r1_data1 = '0, r1_data2 = '0;
  logic [6:0]  r0_optype = '0, r1_optype = '0, r0_funct7 = '0, r1_funct7 = '0;
  logic [2:0]  r0_aluop = '0, r1_aluop = '0;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_err;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data1(r0_data1), .r0_data2(r0_data2),
    .r0_optype(r0_optype), .r0_aluop(r0_aluop), .r0_funct7(r0_funct7),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data1(r1_data1), .r1_data2(r1_data2),
    .r1_optype(r1_optype), .r1_aluop(r1_aluop), .r1_funct7(r1_funct7),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  // ALU vectors: optype, funct3, funct7, data1, data2 -> result, zero, carry
  localparam int NV = 10;
  localparam logic [6:0]  V_OP [NV] = '{OPR, OPR, OPR, OPR, OPR, OPI, OPR, OPI, OPR, OPR};
  localparam logic [2:0]  V_F3 [NV] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd3, 3'd7, 3'd1, 3'd0, 3'd6, 3'd5};
  localparam logic [6:0]  V_F7 [NV] = '{F7S, 7'h00, F7S, 7'h00, 7'h00, 7'h00, 7'h00, F7S, 7'h00, F7S};
  localparam logic [31:0] V_A  [NV] = '{32'd3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                        32'hFF00_FF00, 32'd1, 32'd5, 32'h0000_00A0, 32'hFFFF_FFF0};
  localparam logic [31:0] V_B  [NV] = '{32'd3, 32'd1, 32'd2, 32'd1, 32'd1,
                                        32'h0FF0_0FF0, 32'h0000_003F, 32'd7, 32'h0000_000B, 32'd2};
  localparam logic [31:0] V_R  [NV] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0,
                                        32'h0F00_0F00, 32'h8000_0000, 32'd12, 32'h0000_00AB, 32'hFFFF_FFFC};
  localparam logic        V_Z  [NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic        V_C  [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic drive_req(input bit r, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    if (!r) begin
      r0_valid = 1'b1; r0_optype = op; r0_aluop = f3; r0_funct7 = f7; r0_data1 = a; r0_data2 = b;
    end else begin
      r1_valid = 1'b1; r1_optype = op; r1_aluop = f3; r1_funct7 = f7; r1_data1 = a; r1_data2 = b;
    end
  endtask

  // Advances negedges until rsp_valid, at most 8; n==8 means it never came.
  task automatic await_resp(output int n);
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL reset_r0_ready: got %b want 0", r0_ready); end
    checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL reset_r1_ready: got %b want 0", r1_ready); end
    checks++; if ({rsp_id, rsp_zero, rsp_carry, rsp_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got id/z/c/e %b want 0000", {rsp_id, rsp_zero, rsp_carry, rsp_err});
    end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", rsp_result); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add;
    @(negedge clk);
    drive_req(0, OPR, 3'd0, 7'h00, 32'd5, 32'd7);
    #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL add_accept: got r0/r1 ready %b want 10", {r0_ready, r1_ready}); end
    @(negedge clk); #1;
    checks++; if ({r0_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL add_exec: got ready/valid %b want 00", {r0_ready, rsp_valid}); end
    @(negedge clk); r0_valid = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency: got rsp_valid %b want 1", rsp_valid); end
    checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL add_result: got %h want 0000000c", rsp_result); end
    checks++; if ({rsp_zero, rsp_id} !== 2'b00) begin errors++; $display("FAIL add_zero_id: got %b want 00", {rsp_zero, rsp_id}); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_idle: got rsp_valid %b want 0", rsp_valid); end
  endtask

  task automatic test_alu_ops;
    int n;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_req(0, V_OP[i], V_F3[i], V_F7[i], V_A[i], V_B[i]);
      @(negedge clk); r0_valid = 1'b0; #1;
      await_resp(n);
      checks++; if (n >= 8) begin errors++; $display("FAIL alu_timeout[%0d]: no rsp_valid", i); end
      checks++; if (rsp_result !== V_R[i]) begin errors++; $display("FAIL alu_result[%0d]: got %h want %h", i, rsp_result, V_R[i]); end
      checks++; if ({rsp_zero, rsp_carry, rsp_err} !== {V_Z[i], V_C[i], 1'b0}) begin
        errors++; $display("FAIL alu_flags[%0d]: got z/c/e %b want %b", i, {rsp_zero, rsp_carry, rsp_err}, {V_Z[i], V_C[i], 1'b0});
      end
    end
  endtask

  task automatic test_err;
    int n;
    @(negedge clk);
    drive_req(0, 7'h63, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk); r0_valid = 1'b0; #1;
    await_resp(n);
    checks++; if (n >= 8) begin errors++; $display("FAIL err_timeout: no rsp_valid"); end
    checks++; if ({rsp_err, rsp_zero, rsp_carry} !== 3'b110) begin
      errors++; $display("FAIL err_flags: got e/z/c %b want 110", {rsp_err, rsp_zero, rsp_carry});
    end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL err_result: got %h want 0", rsp_result); end
  endtask

  task automatic test_srai;
    int n;
    @(negedge clk);
    drive_req(0, OPI, 3'd5, 7'h00, 32'h8000_0000, 32'd4);
    @(negedge clk); r0_valid = 1'b0; #1;
    await_resp(n);
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'h0800_0000}) begin
      errors++; $display("FAIL srli: got v/id %b%b result %h want 10 08000000", rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
    drive_req(1, OPI, 3'd5, F7S, 32'h8000_0000, 32'd4);
    #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b01) begin errors++; $display("FAIL srai_accept: got r0/r1 ready %b want 01", {r0_ready, r1_ready}); end
    @(negedge clk); r1_valid = 1'b0; #1;
    await_resp(n);
    checks++; if (n >= 8) begin errors++; $display("FAIL srai_timeout: no rsp_valid"); end
    checks++; if (rsp_result !== 32'hF800_0000) begin errors++; $display("FAIL srai_result: got %h want f8000000", rsp_result); end
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL srai_id: got %b want 1", rsp_id); end
  endtask

  task automatic test_back_to_back;
    int exp_g;
    int prev;
    prev = 0;
    @(negedge clk);
    drive_req(0, OPR, 3'd0, 7'h00, 32'd1, 32'd1);
    drive_req(1, OPR, 3'd0, 7'h00, 32'd2, 32'd2);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = RR ? (k % 2) : 0;
      if (k > 0) begin
        checks++; if ({rsp_valid, rsp_id} !== {1'b1, prev[0]}) begin
          errors++; $display("FAIL b2b_rsp[%0d]: got v/id %b%b want 1%0d", k, rsp_valid, rsp_id, prev);
        end
        checks++; if (rsp_result !== (prev == 1 ? 32'd4 : 32'd2)) begin
          errors++; $display("FAIL b2b_result[%0d]: got %h want %0d", k, rsp_result, prev == 1 ? 4 : 2);
        end
      end
      checks++; if ({r0_ready, r1_ready} !== {exp_g == 0, exp_g == 1}) begin
        errors++; $display("FAIL b2b_grant[%0d]: got r0/r1 ready %b want grant %0d", k, {r0_ready, r1_ready}, exp_g);
      end
      prev = exp_g;
      @(negedge clk); #1;
      checks++; if ({r0_ready, r1_ready, rsp_valid} !== 3'b000) begin
        errors++; $display("FAIL b2b_exec[%0d]: got ready/ready/valid %b want 000", k, {r0_ready, r1_ready, rsp_valid});
      end
      @(negedge clk);
      if (k == 3) begin r0_valid = 1'b0; r1_valid = 1'b0; end
      #1;
    end
    checks++; if ({rsp_valid, rsp_id, r0_ready, r1_ready} !== {1'b1, prev[0], 2'b00}) begin
      errors++; $display("FAIL b2b_last: got v/id/rdy %b want 1%0d00", {rsp_valid, rsp_id, r0_ready, r1_ready}, prev);
    end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(0, OPR, 3'd0, 7'h00, 32'd10, 32'd20);
    @(negedge clk);
    r0_valid = 1'b0;
    drive_req(1, OPR, 3'd0, 7'h00, 32'd100, 32'd1);
    #1;
    await_resp(n);
    checks++; if (n >= 8) begin errors++; $display("FAIL bp_timeout: no rsp_valid"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_err, rsp_result} !== {5'b10000, 32'd30}) begin
        errors++; $display("FAIL bp_hold[%0d]: got v/id/z/c/e %b result %h want 10000 0000001e", i,
                           {rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_err}, rsp_result);
      end
      checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {r0_ready, r1_ready}); end
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if ({rsp_valid, r0_ready, r1_ready} !== 3'b101) begin
      errors++; $display("FAIL bp_release: got valid/r0/r1 %b want 101", {rsp_valid, r0_ready, r1_ready});
    end
    @(negedge clk); r1_valid = 1'b0; #1;
    @(negedge clk); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {2'b11, 32'd101}) begin
      errors++; $display("FAIL bp_next: got v/id %b%b result %h want 11 00000065", rsp_valid, rsp_id, rsp_result);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive_req(0, OPR, 3'd0, 7'h00, 32'd5, 32'd7);
    @(negedge clk);
    rst_n = 1'b0; r0_valid = 1'b0;
    drive_req(1, OPR, 3'd0, 7'h00, 32'd100, 32'd1);
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_err, rsp_result} !== 37'd0) begin
      errors++; $display("FAIL rmid_outputs: got v/id/z/c/e %b result %h want all 0",
                         {rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_err}, rsp_result);
    end
    checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL rmid_ready: got %b want 00", {r0_ready, r1_ready}); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_hold: got rsp_valid %b want 0", rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(0, OPR, 3'd4, 7'h00, 32'h0000_F0F0, 32'h0000_0FF0);
    #1;
    checks++; if ({r0_ready, r1_ready, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL rmid_first_grant: got r0/r1/valid %b want 100", {r0_ready, r1_ready, rsp_valid});
    end
    @(negedge clk); r0_valid = 1'b0; r1_valid = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_exec: got rsp_valid %b want 0", rsp_valid); end
    @(negedge clk); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'h0000_FF00}) begin
      errors++; $display("FAIL rmid_resp: got v/id %b%b result %h want 10 0000ff00", rsp_valid, rsp_id, rsp_result);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_err();
    test_srai();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
